// File: rtl/dcm_clk_monitor.sv
// -----------------------------------------------------------------------------
// dcm_clk_monitor
//
// Supervisor for the DCM clock generator. Runs on the board clock, pulses the
// DCM reset, waits for lock, then counts rising edges of the generated clock
// over fixed windows. The clock is declared good only while each window's
// count stays within EXP_COUNT +/- TOL. Consecutive failed attempts are
// counted, and reaching MAX_RETRY latches a sticky fault.
//
// Ports:
//   CLK_IN1     in   board clock; all logic runs on its rising edge
//   RESET_N     in   async-assert, active-low reset; release synchronized here
//   CLK_MON     in   clock under test, asynchronous to CLK_IN1
//   DCM_RESET   out  DCM reset request (registered, high while in reset pulse)
//   CLK_OK      out  monitored clock within tolerance (registered)
//   FAIL        out  sticky fault after MAX_RETRY consecutive failures
//   EDGE_COUNT  out  edge count of the last completed window (saturating)
//   RETRY_COUNT out  consecutive failed attempts
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dcm_clk_monitor #(
  parameter int RST_CYCLES = 3,
  parameter int LOCK_WAIT  = 65536,
  parameter int WINDOW     = 1000,
  parameter int EXP_COUNT  = 240,
  parameter int TOL        = 4,
  parameter int MAX_RETRY  = 7
) (
  input  logic        CLK_IN1,
  input  logic        RESET_N,
  input  logic        CLK_MON,
  output logic        DCM_RESET,
  output logic        CLK_OK,
  output logic        FAIL,
  output logic [11:0] EDGE_COUNT,
  output logic [2:0]  RETRY_COUNT
);

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  // One phase counter serves the reset pulse, the lock wait and the window,
  // so it is sized for the longest of the three.
  localparam int CMAX = (LOCK_WAIT > WINDOW)
                        ? ((LOCK_WAIT > RST_CYCLES) ? LOCK_WAIT : RST_CYCLES)
                        : ((WINDOW > RST_CYCLES) ? WINDOW : RST_CYCLES);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);

  // Tolerance bounds clamped to the 12-bit count range.
  localparam int LO_I = EXP_COUNT - TOL;
  localparam int HI_I = EXP_COUNT + TOL;
  localparam int LO_C = (LO_I < 0) ? 0 : ((LO_I > 4095) ? 4095 : LO_I);
  localparam int HI_C = (HI_I < 0) ? 0 : ((HI_I > 4095) ? 4095 : HI_I);
  localparam logic [11:0] LO_CNT = 12'(LO_C);
  localparam logic [11:0] HI_CNT = 12'(HI_C);
  localparam logic [2:0]  MAX_R  = 3'(MAX_RETRY);

  // Reset: assertion is immediate, release is delayed by two flops so every
  // register leaves reset on the same clean edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // CLK_MON: two synchronizer flops plus one history flop for edge detect.
  logic [2:0] mon_q;
  logic       mon_edge;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would turn the shift
  // register into a single flop.
  always_ff @(posedge CLK_IN1 or negedge rst_n) begin
    if (!rst_n) mon_q <= 3'b000;
    else        mon_q <= {mon_q[1:0], CLK_MON};
  end

  assign mon_edge = mon_q[1] & ~mon_q[2];

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [11:0]   ecnt_q, ecnt_d;
  logic [11:0]   edge_cnt_q, edge_cnt_d;
  logic          ok_q, ok_d;
  logic [2:0]    retry_q, retry_d;
  logic          dcm_reset_q, dcm_reset_d;
  logic          fail_q, fail_d;

  logic [11:0] ecnt_sum;
  logic        win_pass;
  logic [2:0]  retry_inc;
  logic        measuring;

  // Running count including this cycle's edge, held at 4095.
  assign ecnt_sum  = (ecnt_q == 12'hFFF) ? ecnt_q : ecnt_q + {11'd0, mon_edge};
  assign win_pass  = (ecnt_sum >= LO_CNT) && (ecnt_sum <= HI_CNT);
  assign retry_inc = retry_q + 3'd1;
  assign measuring = (state_q == S_MEAS) || (state_q == S_RUN) || (state_q == S_FAIL);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q + CW'(1);
    ecnt_d     = measuring ? ecnt_sum : 12'd0;  // edges outside windows are dropped
    edge_cnt_d = edge_cnt_q;
    ok_d       = ok_q;
    retry_d    = retry_q;

    case (state_q)
      S_RST: begin
        if (tcnt_q == RST_LAST) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (tcnt_q == WAIT_LAST) begin
          state_d = S_MEAS;
          tcnt_d  = '0;
        end
      end
      S_MEAS, S_RUN, S_FAIL: begin
        if (tcnt_q == WIN_LAST) begin
          // Windows abut: the next one starts on the very next cycle.
          tcnt_d     = '0;
          ecnt_d     = 12'd0;
          edge_cnt_d = ecnt_sum;
          if (state_q == S_MEAS) begin
            if (win_pass) begin
              ok_d    = 1'b1;
              retry_d = 3'd0;
              state_d = S_RUN;
            end else begin
              retry_d = retry_inc;
              state_d = (retry_inc == MAX_R) ? S_FAIL : S_RST;
            end
          end else if (state_q == S_RUN) begin
            if (!win_pass) begin
              ok_d    = 1'b0;
              retry_d = 3'd1;
              state_d = (MAX_RETRY == 1) ? S_FAIL : S_RST;
            end
          end
        end
      end
      default: begin
        state_d = S_RST;
        tcnt_d  = '0;
      end
    endcase

    if (state_d == S_FAIL) ok_d = 1'b0;
    dcm_reset_d = (state_d == S_RST);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge CLK_IN1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      tcnt_q      <= '0;
      ecnt_q      <= 12'd0;
      edge_cnt_q  <= 12'd0;
      ok_q        <= 1'b0;
      retry_q     <= 3'd0;
      dcm_reset_q <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      ecnt_q      <= ecnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ok_q        <= ok_d;
      retry_q     <= retry_d;
      dcm_reset_q <= dcm_reset_d;
      fail_q      <= fail_d;
    end
  end

  assign DCM_RESET   = dcm_reset_q;
  assign CLK_OK      = ok_q;
  assign FAIL        = fail_q;
  assign EDGE_COUNT  = edge_cnt_q;
  assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_dcm_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_dcm_clk_monitor
//
// Bench for dcm_clk_monitor with small timing parameters. Exact-count windows
// are driven with a clock-synchronous CLK_MON pattern; free-running 24/12 MHz
// stimulus uses an asynchronous generator. Expected outputs come from a
// window-level model of the supervisor rules (pass/fail, retries, fault).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dcm_clk_monitor;

  localparam int RST_CYCLES = 3;
  localparam int LOCK_WAIT  = 16;
  localparam int WINDOW     = 100;
  localparam int EXP_COUNT  = 24;
  localparam int TOL        = 2;
  localparam int MAX_RETRY  = 3;
  localparam int LO         = EXP_COUNT - TOL;
  localparam int HI         = EXP_COUNT + TOL;
  localparam int GAP        = RST_CYCLES + LOCK_WAIT;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        mon_sync  = 1'b0;
  logic        mon_async = 1'b0;
  logic        async_en  = 1'b0;
  real         mon_half  = 20.833;
  logic        clk_mon;
  logic        dcm_reset;
  logic        clk_ok;
  logic        fail;
  logic [11:0] edge_count;
  logic [2:0]  retry_count;

  int n_checks = 0;
  int n_errors = 0;

  // Window-level reference model.
  int m_retry;
  bit m_ok;
  bit m_fail;
  bit m_run;

  assign clk_mon = async_en ? mon_async : mon_sync;

  always #5 clk = ~clk;
  always #(mon_half) mon_async = ~mon_async;

  dcm_clk_monitor #(
    .RST_CYCLES(RST_CYCLES),
    .LOCK_WAIT (LOCK_WAIT),
    .WINDOW    (WINDOW),
    .EXP_COUNT (EXP_COUNT),
    .TOL       (TOL),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .CLK_IN1    (clk),
    .RESET_N    (rst_n),
    .CLK_MON    (clk_mon),
    .DCM_RESET  (dcm_reset),
    .CLK_OK     (clk_ok),
    .FAIL       (fail),
    .EDGE_COUNT (edge_count),
    .RETRY_COUNT(retry_count)
  );

  // Hold reset, check reset values, release #1 after an edge (E0), check the
  // reset pulse, and return #1 after E21 where the first window begins.
  task automatic reset_and_align();
    rst_n    = 1'b0;
    mon_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dcm_reset !== 1'b1 || clk_ok !== 1'b0 || fail !== 1'b0 ||
        edge_count !== 12'd0 || retry_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_values: dcm=%b ok=%b fail=%b edge=%0d retry=%0d, want 1 0 0 0 0",
               dcm_reset, clk_ok, fail, edge_count, retry_count);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dcm_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pulse_hold: dcm_reset=%b at E4, want 1", dcm_reset);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dcm_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_pulse_end: dcm_reset=%b at E5, want 0", dcm_reset);
    end
    repeat (LOCK_WAIT) @(posedge clk);
    #1;
    m_ok    = 1'b0;
    m_retry = 0;
    m_fail  = 1'b0;
    m_run   = 1'b0;
  endtask

  // Exactly n rising edges, one every 3 cycles starting at offset 5, all
  // landing well inside the window after synchronizer latency.
  task automatic drive_window(input int n, input int len);
    for (int t = 0; t < len; t++) begin
      mon_sync = (t >= 5 && t < 5 + 3 * n && ((t - 5) % 3) == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    mon_sync = 1'b0;
  endtask

  // Drive one window of n edges, check outputs at its terminal update, and
  // advance to the start of the next window.
  task automatic window_step(input int n);
    bit pass;
    int gap;
    drive_window(n, WINDOW);
    pass = (n >= LO) && (n <= HI);
    gap  = 0;
    if (m_fail) begin
      gap = 0;
    end else if (m_run) begin
      if (!pass) begin
        m_ok    = 1'b0;
        m_retry = 1;
        if (MAX_RETRY == 1) m_fail = 1'b1;
        else begin
          m_run = 1'b0;
          gap   = GAP;
        end
      end
    end else begin
      if (pass) begin
        m_ok    = 1'b1;
        m_retry = 0;
        m_run   = 1'b1;
      end else begin
        m_retry++;
        if (m_retry == MAX_RETRY) m_fail = 1'b1;
        else gap = GAP;
      end
    end
    if (m_fail) m_ok = 1'b0;

    n_checks++;
    if (edge_count !== 12'(n)) begin
      n_errors++;
      $display("FAIL edge_count(n=%0d): got %0d, want %0d", n, edge_count, n);
    end
    n_checks++;
    if (clk_ok !== m_ok || retry_count !== 3'(m_retry) || fail !== m_fail) begin
      n_errors++;
      $display("FAIL window_status(n=%0d): ok=%b retry=%0d fail=%b, want %b %0d %b",
               n, clk_ok, retry_count, fail, m_ok, m_retry, m_fail);
    end
    n_checks++;
    if (dcm_reset !== ((gap != 0) ? 1'b1 : 1'b0)) begin
      n_errors++;
      $display("FAIL dcm_after_window(n=%0d): got %b, want %b", n, dcm_reset, gap != 0);
    end
    if (gap != 0) begin
      repeat (RST_CYCLES - 1) @(posedge clk);
      #1;
      n_checks++;
      if (dcm_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL retry_pulse_hold: dcm_reset=%b, want 1", dcm_reset);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (dcm_reset !== 1'b0) begin
        n_errors++;
        $display("FAIL retry_pulse_end: dcm_reset=%b, want 0", dcm_reset);
      end
      repeat (gap - RST_CYCLES) @(posedge clk);
      #1;
    end
  endtask

  // Poll for clk_ok == want for at most limit cycles; returns cycles waited.
  task automatic wait_ok(input logic want, input int limit, output int k);
    k = 0;
    while (clk_ok !== want && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_nominal();
    int k;
    async_en = 1'b1;
    mon_half = 20.833;
    reset_and_align();
    wait_ok(1'b1, 200, k);
    // k counts from E21; S_RST entry (sync done) is E2.
    n_checks++;
    if (clk_ok !== 1'b1 || (k + 19) < 119 || (k + 19) > 121) begin
      n_errors++;
      $display("FAIL nominal_ok_rise: ok=%b after %0d cycles, want 1 within 119..121",
               clk_ok, k + 19);
    end
    for (int w = 0; w < 20; w++) begin
      repeat (WINDOW) @(posedge clk);
      #1;
      n_checks++;
      if (clk_ok !== 1'b1 || retry_count !== 3'd0 || fail !== 1'b0 ||
          edge_count < 12'd23 || edge_count > 12'd25) begin
        n_errors++;
        $display("FAIL nominal_run[%0d]: ok=%b retry=%0d fail=%b edge=%0d, want 1 0 0 23..25",
                 w, clk_ok, retry_count, fail, edge_count);
      end
    end
  endtask

  task automatic test_loss_in_run();
    int k;
    async_en = 1'b1;
    mon_half = 20.833;
    reset_and_align();
    wait_ok(1'b1, 200, k);
    mon_half = 41.667;
    wait_ok(1'b0, 250, k);
    n_checks++;
    if (clk_ok !== 1'b0 || k > 2 * WINDOW) begin
      n_errors++;
      $display("FAIL loss_detect: ok=%b after %0d cycles, want 0 within %0d", clk_ok, k, 2 * WINDOW);
    end
    n_checks++;
    if (edge_count < 12'd10 || edge_count > 12'd14 || retry_count !== 3'd1 || dcm_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL loss_status: edge=%0d retry=%0d dcm=%b, want 10..14 1 1",
               edge_count, retry_count, dcm_reset);
    end
    mon_half = 20.833;
    repeat (GAP + WINDOW - 1) @(posedge clk);
    #1;
    n_checks++;
    if (clk_ok !== 1'b0) begin
      n_errors++;
      $display("FAIL recover_early: ok=%b one cycle before recovery, want 0", clk_ok);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (clk_ok !== 1'b1 || retry_count !== 3'd0) begin
      n_errors++;
      $display("FAIL recover: ok=%b retry=%0d, want 1 0", clk_ok, retry_count);
    end
    async_en = 1'b0;
  endtask

  task automatic test_dead_clock();
    async_en = 1'b0;
    reset_and_align();
    for (int w = 0; w < MAX_RETRY + 10; w++) window_step(0);
  endtask

  task automatic test_tolerance();
    int ns[$];
    ns = '{LO - 1, LO, HI, HI + 1};
    for (int i = 0; i < 6; i++) ns.push_back(int'($urandom_range(18, 30)));
    async_en = 1'b0;
    foreach (ns[i]) begin
      reset_and_align();
      window_step(ns[i]);
    end
  endtask

  task automatic test_reset_mid();
    async_en = 1'b0;
    // Mid-window abort with two retries accumulated.
    reset_and_align();
    window_step(18);
    window_step(19);
    drive_window(24, 50);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dcm_reset !== 1'b1 || clk_ok !== 1'b0 || fail !== 1'b0 ||
        edge_count !== 12'd0 || retry_count !== 3'd0) begin
      n_errors++;
      $display("FAIL abort_retry: dcm=%b ok=%b fail=%b edge=%0d retry=%0d, want 1 0 0 0 0",
               dcm_reset, clk_ok, fail, edge_count, retry_count);
    end
    // Mid-window abort while running.
    reset_and_align();
    window_step(24);
    drive_window(24, 50);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dcm_reset !== 1'b1 || clk_ok !== 1'b0 || edge_count !== 12'd0 || retry_count !== 3'd0) begin
      n_errors++;
      $display("FAIL abort_run: dcm=%b ok=%b edge=%0d retry=%0d, want 1 0 0 0",
               dcm_reset, clk_ok, edge_count, retry_count);
    end
    // Full startup again.
    reset_and_align();
    window_step(24);
    window_step(23);
  endtask

  task automatic test_random();
    int n;
    async_en = 1'b0;
    for (int r = 0; r < 4; r++) begin
      reset_and_align();
      for (int w = 0; w < 10; w++) begin
        if ($urandom_range(0, 9) < 6) n = int'($urandom_range(LO, HI));
        else if ($urandom_range(0, 1) == 0) n = int'($urandom_range(14, LO - 1));
        else n = int'($urandom_range(HI + 1, 30));
        window_step(n);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_nominal();
    test_loss_in_run();
    test_dead_clock();
    test_tolerance();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
